ntt_result_writeback: RTL and testbench

Writes the NTT result stream back into the shared data memory. Each accepted beat of `LANE` 32-bit words from the NTT core's output port is buffered and stored as one vector write on port B of the dual-port memory. After the last beat it writes a completion flag word that software polls. It is the writer for the memory→NTT feed: the feed reads operands out of memory, this block returns results to it.

---
 rtl/ntt_pkg.sv | 22 ++
 rtl/ntt_wb_fifo.sv | 50 +++++
 rtl/ntt_result_writeback.sv | 144 ++++++++++++++
 tb/tb_ntt_result_writeback.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
`default_nettype none
// ntt_pkg: shared NTT datapath types, address map and writeback FSM states (rev 1.0)
package ntt_pkg;

  localparam int LANE           = 8;
  localparam int NUM_BEATS      = 64;
  localparam int NTT_START_ADDR = 512;
  localparam int NTT_FLAG_ADDR  = 513;
  localparam logic [31:0] FLAG_VAL = 32'hFFFF_FFFF;

  typedef logic [31:0] lane_t;
  typedef lane_t [LANE-1:0] type_vector;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLAG   = 2'd2,
    ST_DONE   = 2'd3
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/ntt_wb_fifo.sv
`default_nettype none
// ntt_wb_fifo: synchronous FIFO with full/empty/count; push on full is accepted when a pop coincides (rev 1.0)
module ntt_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/ntt_result_writeback.sv
`default_nettype none
// ntt_result_writeback: buffers NTT result beats, writes them to memory port B, then a completion flag (rev 1.0)
module ntt_result_writeback
  import ntt_pkg::*;
#(
  parameter int          LANE       = ntt_pkg::LANE,
  parameter int          NUM_BEATS  = ntt_pkg::NUM_BEATS,
  parameter int          AW         = 14,
  parameter int          BASE_ADDR  = 0,
  parameter int          FLAG_ADDR  = ntt_pkg::NTT_FLAG_ADDR,
  parameter logic [31:0] FLAG_VAL   = ntt_pkg::FLAG_VAL,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            lane_valid,
  input  type_vector      lane_data,
  output logic            mem_wen,
  output logic            mem_vec,
  output logic [3:0]      mem_be,
  output logic [AW-1:0]   mem_addr,
  output type_vector      mem_data,
  input  logic            mem_gnt,
  output logic            busy,
  output logic            done,
  output logic            overflow
);

  localparam int IW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int CW = $clog2(NUM_BEATS + 1);
  localparam int DW = $bits(type_vector);
  localparam int FW = IW + DW;
  localparam int QW = $clog2(FIFO_DEPTH) + 1;

  wb_state_t       r_state;
  wb_state_t       w_state_next;
  logic [CW-1:0]   r_push_cnt;
  logic [CW-1:0]   w_push_cnt_next;
  logic            r_overflow;

  logic            w_accept;
  logic            w_pop;
  logic            w_fifo_push;
  logic            w_drop;
  logic [FW-1:0]   w_head;
  logic            w_full;
  logic            w_empty;
  logic [QW-1:0]   w_count;
  logic [QW-1:0]   w_count_next;
  logic            w_fifo_will_empty;
  logic [IW-1:0]   w_head_idx;
  type_vector      w_head_data;
  logic [AW-1:0]   w_vec_addr;

  assign w_accept    = (r_state == ST_STREAM) && lane_valid && (r_push_cnt < CW'(NUM_BEATS));
  assign w_pop       = (r_state == ST_STREAM) && !w_empty && mem_gnt;
  assign w_fifo_push = w_accept && (!w_full || w_pop);
  assign w_drop      = (r_state == ST_STREAM) && lane_valid && !w_fifo_push;

  assign w_push_cnt_next   = r_push_cnt + CW'(w_accept);
  assign w_count_next      = w_count + QW'(w_fifo_push) - QW'(w_pop);
  assign w_fifo_will_empty = (w_count_next == '0);

  assign w_head_idx  = w_head[FW-1 -: IW];
  assign w_head_data = w_head[DW-1:0];
  assign w_vec_addr  = AW'(BASE_ADDR) + AW'(LANE) * AW'(w_head_idx);
  assign overflow    = r_overflow;

  ntt_wb_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fifo_push),
    .i_pop   (w_pop),
    .i_data  ({r_push_cnt[IW-1:0], lane_data}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_push_cnt <= '0;
      r_overflow <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_push_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_push_cnt <= w_push_cnt_next;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Leaving STREAM looks at next-cycle counts so the flag follows the last commit directly.
  always_comb begin
    w_state_next = r_state;
    mem_wen      = 1'b0;
    mem_vec      = 1'b0;
    mem_be       = 4'h0;
    mem_addr     = '0;
    mem_data     = '0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = ST_STREAM;
      end
      ST_STREAM: begin
        if (!w_empty) begin
          mem_wen  = 1'b1;
          mem_vec  = 1'b1;
          mem_addr = w_vec_addr;
          mem_data = w_head_data;
        end
        if ((w_push_cnt_next == CW'(NUM_BEATS)) && w_fifo_will_empty)
          w_state_next = ST_FLAG;
      end
      ST_FLAG: begin
        mem_wen     = 1'b1;
        mem_be      = 4'hF;
        mem_addr    = AW'(FLAG_ADDR);
        mem_data[0] = FLAG_VAL;
        if (mem_gnt) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_result_writeback.sv
`default_nettype none
// tb_ntt_result_writeback: randomized directed scenarios checked against a queue-level reference model (rev 1.0)
module tb_ntt_result_writeback;
  import ntt_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        lane_valid;
  type_vector  lane_data;
  logic        mem_wen;
  logic        mem_vec;
  logic [3:0]  mem_be;
  logic [13:0] mem_addr;
  type_vector  mem_data;
  logic        mem_gnt;
  logic        busy;
  logic        done;
  logic        overflow;

  ntt_result_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .lane_valid (lane_valid),
    .lane_data  (lane_data),
    .mem_wen    (mem_wen),
    .mem_vec    (mem_vec),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_gnt    (mem_gnt),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] act_mem [0:1023];
  int          act_cnt [0:1023];
  logic [31:0] exp_mem [0:1023];
  bit          exp_wr  [0:1023];
  int          flag_cnt, flag_cyc, done_cnt, done_cyc, last_vec_cyc;
  logic [31:0] flag_val;
  logic [3:0]  flag_be;
  logic [13:0] flag_addr;
  int          vec_order[$];

  int m_q[$];
  int m_pcnt;
  bit m_ovf;
  bit m_stream;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < 1024; i++) begin
      act_mem[i] = '0; act_cnt[i] = 0; exp_mem[i] = '0; exp_wr[i] = 1'b0;
    end
    flag_cnt = 0; flag_cyc = -1; done_cnt = 0; done_cyc = -1; last_vec_cyc = -1;
    flag_val = '0; flag_be = '0; flag_addr = '0;
    vec_order.delete();
  endtask

  // One clock: drive, observe commits at negedge, advance the model at the edge.
  task automatic step(input bit st, input bit v, input bit g);
    type_vector d;
    bit dn;
    for (int k = 0; k < LANE; k++) d[k] = $urandom();
    start = st; lane_valid = v; mem_gnt = g; lane_data = d;
    @(negedge clk);
    dn = done;
    if (mem_wen && mem_gnt) begin
      if (mem_vec) begin
        for (int k = 0; k < LANE; k++) begin
          act_mem[int'(mem_addr) + k] = mem_data[k];
          act_cnt[int'(mem_addr) + k]++;
        end
        vec_order.push_back(int'(mem_addr));
        last_vec_cyc = cyc;
      end else begin
        flag_cnt++; flag_val = mem_data[0]; flag_be = mem_be; flag_addr = mem_addr; flag_cyc = cyc;
      end
    end
    if (dn) begin done_cnt++; done_cyc = cyc; end
    if (m_stream) begin
      if (m_q.size() > 0 && g) void'(m_q.pop_front());
      if (v) begin
        if (m_pcnt < NUM_BEATS) begin
          if (m_q.size() < 4) begin
            m_q.push_back(m_pcnt);
            for (int k = 0; k < LANE; k++) begin
              exp_mem[8*m_pcnt + k] = d[k];
              exp_wr[8*m_pcnt + k]  = 1'b1;
            end
          end else m_ovf = 1'b1;
          m_pcnt++;
        end else m_ovf = 1'b1;
      end
    end else if (st) begin
      m_stream = 1'b1; m_pcnt = 0; m_ovf = 1'b0; m_q.delete();
    end
    if (dn) m_stream = 1'b0;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && done_cnt == 0; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_run(input string tag, input bit exp_ovf);
    bit ok;
    for (int b = 0; b < NUM_BEATS; b++) begin
      ok = 1'b1;
      for (int k = 0; k < LANE; k++) begin
        if (exp_wr[8*b+k]) ok &= (act_cnt[8*b+k] == 1) && (act_mem[8*b+k] === exp_mem[8*b+k]);
        else               ok &= (act_cnt[8*b+k] == 0);
      end
      chk($sformatf("%s_beat%0d", tag, b), ok, 1'b1);
    end
    chk({tag, "_flag_cnt"},  flag_cnt, 1);
    chk({tag, "_flag_val"},  flag_val, 32'hFFFF_FFFF);
    chk({tag, "_flag_be"},   flag_be, 4'hF);
    chk({tag, "_flag_addr"}, flag_addr, 14'd513);
    chk({tag, "_done_cnt"},  done_cnt, 1);
    chk({tag, "_ovf_model"}, overflow, m_ovf);
    chk({tag, "_ovf"},       overflow, exp_ovf);
    chk({tag, "_busy_end"},  busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wen"},  mem_wen, 1'b0);
    chk({tag, "_vec"},  mem_vec, 1'b0);
    chk({tag, "_be"},   mem_be, 4'h0);
    chk({tag, "_addr"}, mem_addr, 14'h0);
    chk({tag, "_data"}, (mem_data == '0), 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_ovf"},  overflow, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; lane_valid = 1'b0; mem_gnt = 1'b0; lane_data = '0;
    m_stream = 1'b0; m_pcnt = 0; m_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // 64 back-to-back beats with permanent grant.
    clear_log();
    step(1'b1, 1'b0, 1'b1);
    chk("s1_busy", busy, 1'b1);
    for (int i = 0; i < NUM_BEATS; i++) step(1'b0, 1'b1, 1'b1);
    wait_done();
    chk("s1_order_len", vec_order.size(), NUM_BEATS);
    for (int i = 0; i < vec_order.size(); i++) chk($sformatf("s1_addr%0d", i), vec_order[i], 8*i);
    chk("s1_flag_lat", flag_cyc - last_vec_cyc, 1);
    chk("s1_done_lat", done_cyc - last_vec_cyc, 2);
    check_run("s1", 1'b0);

    // Grant toggling, one beat every other cycle.
    clear_log();
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2*NUM_BEATS; i++) step(1'b0, (i % 2) == 0, (i % 2) == 1);
    wait_done();
    check_run("s2", 1'b0);

    // Grant held low for 6 cycles over beats 0..4: beat 4 overflows.
    clear_log();
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 5; i < NUM_BEATS; i++) step(1'b0, 1'b1, 1'b1);
    wait_done();
    chk("s3_hole32", act_cnt[32], 0);
    check_run("s3", 1'b1);

    // 65 valids: the extra one is dropped.
    clear_log();
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < NUM_BEATS + 1; i++) step(1'b0, 1'b1, 1'b1);
    wait_done();
    check_run("s4", 1'b1);

    // start pulsed mid-stream is ignored.
    clear_log();
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("s5_busy", busy, 1'b1);
    for (int i = 31; i < NUM_BEATS; i++) step(1'b0, 1'b1, 1'b1);
    wait_done();
    check_run("s5", 1'b0);

    // Reset after beat 20 commits aborts without a flag write.
    clear_log();
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 21; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("s6_beat20_written", act_cnt[160], 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("s6_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    m_stream = 1'b0; m_q.delete();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
    chk("s6_no_flag", flag_cnt, 0);
    chk("s6_no_done", done_cnt, 0);

    // Fresh transform with random valid/grant.
    clear_log();
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2000 && m_pcnt < NUM_BEATS; i++)
      step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    wait_done();
    check_run("s7", m_ovf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
